bp_gateway_cmd_router: RTL and testbench

- Parametrised N-target successor to the fixed single-mem/single-host wiring in the gateway testbench.
- Accepts one BedRock-style command stream and steers each command to one of num_targets_p targets (DRAM model, host MMIO, cfg, ...) by programmable base/mask address match.
- Returns responses to the source strictly in command order via an outstanding-target FIFO.
- Unmapped addresses get an internally generated error response, so software bugs hang no target.

---
 rtl/bp_gateway_cmd_router.sv | 158 +++++++++++++++
 tb/tb_bp_gateway_cmd_router.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_gateway_cmd_router.sv
// Routes one command stream to N targets by base/mask match and
// returns responses in command order through a tracking FIFO.
module bp_gateway_cmd_router #(
  parameter int num_targets_p     = 2,
  parameter int addr_width_p      = 40,
  parameter int msg_width_p       = 128,
  parameter int max_outstanding_p = 4,
  parameter int err_count_width_p = 16,
  localparam int cnt_w = $clog2(max_outstanding_p + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_targets_p*addr_width_p-1:0] target_base_i,
  input  logic [num_targets_p*addr_width_p-1:0] target_mask_i,
  input  logic [msg_width_p-1:0]                cmd_i,
  input  logic [addr_width_p-1:0]               cmd_addr_i,
  input  logic                                  cmd_v_i,
  output logic                                  cmd_ready_o,
  output logic [msg_width_p-1:0]                tgt_cmd_o,
  output logic [num_targets_p-1:0]              tgt_cmd_v_o,
  input  logic [num_targets_p-1:0]              tgt_cmd_ready_i,
  input  logic [num_targets_p*msg_width_p-1:0]  tgt_resp_i,
  input  logic [num_targets_p-1:0]              tgt_resp_v_i,
  output logic [num_targets_p-1:0]              tgt_resp_yumi_o,
  output logic [msg_width_p-1:0]                resp_o,
  output logic                                  resp_err_o,
  output logic                                  resp_v_o,
  input  logic                                  resp_yumi_i,
  output logic [cnt_w-1:0]                      outstanding_o,
  output logic [err_count_width_p-1:0]          err_count_o
);

  localparam int sel_w = (num_targets_p > 1) ? $clog2(num_targets_p) : 1;
  localparam int ptr_w = $clog2(max_outstanding_p);
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(max_outstanding_p - 1);
  localparam logic [cnt_w-1:0] depth_c = cnt_w'(max_outstanding_p);

  typedef struct packed {
    logic             err;
    logic [sel_w-1:0] tgt_id;
  } entry_t;

  entry_t                       mem [max_outstanding_p];
  logic [ptr_w-1:0]             rd_ptr, wr_ptr;
  logic [cnt_w-1:0]             count;
  logic [err_count_width_p-1:0] err_count;

  logic [num_targets_p-1:0] hit;
  logic [sel_w-1:0]         sel;
  logic                     unmapped;
  logic                     full, empty, accept, pop, head_rv;
  logic [msg_width_p-1:0]   head_data;
  entry_t                   head;

  // Scan high to low so the lowest-index hit is the last one written.
  always_comb begin
    hit      = '0;
    sel      = '0;
    unmapped = 1'b1;
    for (int k = num_targets_p - 1; k >= 0; k--) begin
      hit[k] = ((cmd_addr_i & target_mask_i[k*addr_width_p +: addr_width_p])
             == (target_base_i[k*addr_width_p +: addr_width_p]
               & target_mask_i[k*addr_width_p +: addr_width_p]));
      if (hit[k]) begin
        sel      = sel_w'(k);
        unmapped = 1'b0;
      end
    end
  end

  assign full   = (count == depth_c);
  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];

  assign cmd_ready_o = ~reset_i & ~full
                     & (unmapped | tgt_cmd_ready_i[sel]);
  assign accept      = cmd_v_i & cmd_ready_o;
  assign tgt_cmd_o   = cmd_i;

  always_comb begin
    tgt_cmd_v_o     = '0;
    tgt_resp_yumi_o = '0;
    head_rv         = 1'b0;
    head_data       = '0;
    if (cmd_v_i & ~full & ~unmapped & ~reset_i)
      tgt_cmd_v_o[sel] = 1'b1;
    for (int k = 0; k < num_targets_p; k++) begin
      if (head.tgt_id == sel_w'(k)) begin
        head_rv   = tgt_resp_v_i[k];
        head_data = tgt_resp_i[k*msg_width_p +: msg_width_p];
        tgt_resp_yumi_o[k] = pop & ~head.err;
      end
    end
  end

  assign resp_v_o   = ~empty & (head.err | head_rv);
  assign resp_err_o = ~empty & head.err;
  assign resp_o     = head.err ? '0 : head_data;
  assign pop        = resp_yumi_i & resp_v_o;

  always_ff @(posedge clk_i) begin
    if (accept) mem[wr_ptr] <= '{err: unmapped, tgt_id: sel};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      err_count <= '0;
    end else begin
      if (accept)
        wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (accept & unmapped & ~(&err_count))
        err_count <= err_count + 1'b1;
    end
  end

  assign outstanding_o = count;
  assign err_count_o   = err_count;

`ifndef SYNTHESIS
  logic [num_targets_p-1:0] pending;

  // Targets that own at least one live, non-error FIFO entry.
  always_comb begin
    pending = '0;
    for (int i = 0; i < max_outstanding_p; i++) begin
      if (((i - int'(rd_ptr) + max_outstanding_p) % max_outstanding_p)
          < int'(count) && !mem[i].err) begin
        for (int k = 0; k < num_targets_p; k++)
          if (mem[i].tgt_id == sel_w'(k)) pending[k] = 1'b1;
      end
    end
  end

  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(resp_yumi_i && !resp_v_o))
        else $error("resp_yumi_i without resp_v_o");
      if (cmd_v_i && $countones(hit) > 1)
        $warning("overlapping target address windows");
      for (int k = 0; k < num_targets_p; k++)
        if (tgt_resp_v_i[k])
          assert (pending[k])
            else $error("target %0d responded with nothing outstanding", k);
    end
  end
`endif

endmodule

// File: tb/tb_bp_gateway_cmd_router.sv
// Scenario bench for bp_gateway_cmd_router with an in-order
// scoreboard of expected responses.
module tb_bp_gateway_cmd_router;

  localparam int NT = 2;
  localparam int AW = 40;
  localparam int MW = 128;
  localparam int MO = 4;
  localparam int EW = 16;
  localparam int CW = $clog2(MO + 1);

  localparam logic [AW-1:0] MASK_A = 40'hFF_8000_0000;
  localparam logic [AW-1:0] ONES   = 40'hFF_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NT*AW-1:0]  base, mask;
  logic [MW-1:0]     cmd;
  logic [AW-1:0]     cmd_addr;
  logic              cmd_v, cmd_ready;
  logic [MW-1:0]     tgt_cmd;
  logic [NT-1:0]     tgt_cmd_v, tgt_cmd_ready;
  logic [NT*MW-1:0]  tgt_resp;
  logic [NT-1:0]     tgt_resp_v, tgt_resp_yumi;
  logic [MW-1:0]     resp;
  logic              resp_err, resp_v, resp_yumi;
  logic [CW-1:0]     outstanding;
  logic [EW-1:0]     err_count;

  bp_gateway_cmd_router #(
    .num_targets_p(NT), .addr_width_p(AW), .msg_width_p(MW),
    .max_outstanding_p(MO), .err_count_width_p(EW)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .target_base_i(base), .target_mask_i(mask),
    .cmd_i(cmd), .cmd_addr_i(cmd_addr), .cmd_v_i(cmd_v),
    .cmd_ready_o(cmd_ready),
    .tgt_cmd_o(tgt_cmd), .tgt_cmd_v_o(tgt_cmd_v),
    .tgt_cmd_ready_i(tgt_cmd_ready),
    .tgt_resp_i(tgt_resp), .tgt_resp_v_i(tgt_resp_v),
    .tgt_resp_yumi_o(tgt_resp_yumi),
    .resp_o(resp), .resp_err_o(resp_err), .resp_v_o(resp_v),
    .resp_yumi_i(resp_yumi),
    .outstanding_o(outstanding), .err_count_o(err_count)
  );

  typedef struct {
    logic          err;
    logic [MW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [MW-1:0] t0q[$];
  int            pass_cnt  = 0;
  int            total_cnt = 0;

  function automatic logic [MW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_map(input logic [AW-1:0] b0, input logic [AW-1:0] m0,
                         input logic [AW-1:0] b1, input logic [AW-1:0] m1);
    base = {b1, b0};
    mask = {m1, m0};
  endtask

  task automatic idle();
    cmd        = '0;
    cmd_addr   = '0;
    cmd_v      = 1'b0;
    tgt_resp   = '0;
    tgt_resp_v = '0;
    resp_yumi  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    t0q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    set_map(40'h8000_0000, MASK_A, 40'h0, MASK_A);
    cmd_addr = 40'h8000_1000;
    cmd_v = 1'b1;
    tgt_cmd_ready = 2'b11;
    #1;
    total_cnt++;
    if (cmd_ready !== 1'b0)
      $display("FAIL rst_ready got %b want 0", cmd_ready);
    else pass_cnt++;
    total_cnt++;
    if (tgt_cmd_v !== 2'b00)
      $display("FAIL rst_tgt_cmd_v got %b want 00", tgt_cmd_v);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    cmd_v = 1'b0;
    #1;
    total_cnt++;
    if (outstanding !== '0 || err_count !== '0 || resp_v !== 1'b0)
      $display("FAIL rst_state got out=%0d err=%0d rv=%b want 0 0 0",
               outstanding, err_count, resp_v);
    else pass_cnt++;
    total_cnt++;
    if (tgt_resp_yumi !== 2'b00)
      $display("FAIL rst_yumi got %b want 00", tgt_resp_yumi);
    else pass_cnt++;
  endtask

  task automatic test_single_hit();
    logic [MW-1:0] p, r;
    do_reset();
    set_map(40'h8000_0000, MASK_A, 40'h0, MASK_A);
    tgt_cmd_ready = 2'b11;
    p = rnd();
    r = rnd();
    @(negedge clk);
    cmd = p;
    cmd_addr = 40'h8000_1000;
    cmd_v = 1'b1;
    #1;
    total_cnt++;
    if (tgt_cmd_v !== 2'b01 || cmd_ready !== 1'b1)
      $display("FAIL hit_route got v=%b rdy=%b want 01 1",
               tgt_cmd_v, cmd_ready);
    else pass_cnt++;
    total_cnt++;
    if (tgt_cmd !== p)
      $display("FAIL hit_payload got %h want %h", tgt_cmd, p);
    else pass_cnt++;
    sb.push_back('{err: 1'b0, data: r});
    @(negedge clk);
    cmd_v = 1'b0;
    #1;
    total_cnt++;
    if (outstanding !== CW'(1) || resp_v !== 1'b0)
      $display("FAIL hit_pending got out=%0d rv=%b want 1 0",
               outstanding, resp_v);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    tgt_resp[0 +: MW] = r;
    tgt_resp_v = 2'b01;
    #1;
    total_cnt++;
    if (resp_v !== 1'b1 || resp_err !== 1'b0 || resp !== sb[0].data)
      $display("FAIL hit_resp got v=%b e=%b d=%h want 1 0 %h",
               resp_v, resp_err, resp, sb[0].data);
    else pass_cnt++;
    resp_yumi = 1'b1;
    #1;
    total_cnt++;
    if (tgt_resp_yumi !== 2'b01)
      $display("FAIL hit_yumi got %b want 01", tgt_resp_yumi);
    else pass_cnt++;
    void'(sb.pop_front());
    @(negedge clk);
    idle();
    #1;
    total_cnt++;
    if (outstanding !== '0 || resp_v !== 1'b0)
      $display("FAIL hit_drain got out=%0d rv=%b want 0 0",
               outstanding, resp_v);
    else pass_cnt++;
  endtask

  task automatic test_reorder();
    logic [MW-1:0] ra, rb;
    do_reset();
    set_map(40'h8000_0000, MASK_A, 40'h0, MASK_A);
    tgt_cmd_ready = 2'b11;
    ra = rnd();
    rb = rnd();
    @(negedge clk);
    cmd_addr = 40'h0000_2000;
    cmd_v = 1'b1;
    #1;
    total_cnt++;
    if (tgt_cmd_v !== 2'b10)
      $display("FAIL ro_route_a got %b want 10", tgt_cmd_v);
    else pass_cnt++;
    sb.push_back('{err: 1'b0, data: ra});
    @(negedge clk);
    cmd_addr = 40'h8000_3000;
    #1;
    total_cnt++;
    if (tgt_cmd_v !== 2'b01)
      $display("FAIL ro_route_b got %b want 01", tgt_cmd_v);
    else pass_cnt++;
    sb.push_back('{err: 1'b0, data: rb});
    @(negedge clk);
    cmd_v = 1'b0;
    tgt_resp[0 +: MW] = rb;
    tgt_resp_v = 2'b01;
    #1;
    total_cnt++;
    if (resp_v !== 1'b0 || tgt_resp_yumi !== 2'b00)
      $display("FAIL ro_hold got rv=%b yumi=%b want 0 00",
               resp_v, tgt_resp_yumi);
    else pass_cnt++;
    @(negedge clk);
    tgt_resp[MW +: MW] = ra;
    tgt_resp_v = 2'b11;
    resp_yumi = 1'b1;
    #1;
    total_cnt++;
    if (resp_v !== 1'b1 || resp !== sb[0].data || tgt_resp_yumi !== 2'b10)
      $display("FAIL ro_first got v=%b d=%h y=%b want 1 %h 10",
               resp_v, resp, tgt_resp_yumi, sb[0].data);
    else pass_cnt++;
    void'(sb.pop_front());
    @(negedge clk);
    tgt_resp_v = 2'b01;
    #1;
    total_cnt++;
    if (resp_v !== 1'b1 || resp !== sb[0].data || tgt_resp_yumi !== 2'b01)
      $display("FAIL ro_second got v=%b d=%h y=%b want 1 %h 01",
               resp_v, resp, tgt_resp_yumi, sb[0].data);
    else pass_cnt++;
    void'(sb.pop_front());
    @(negedge clk);
    idle();
    #1;
    total_cnt++;
    if (outstanding !== '0)
      $display("FAIL ro_drain got %0d want 0", outstanding);
    else pass_cnt++;
  endtask

  task automatic test_unmapped();
    do_reset();
    set_map(40'h8000_0000, ONES, 40'h4000_0000, ONES);
    tgt_cmd_ready = 2'b11;
    @(negedge clk);
    cmd = rnd();
    cmd_addr = 40'h1234;
    cmd_v = 1'b1;
    #1;
    total_cnt++;
    if (tgt_cmd_v !== 2'b00 || cmd_ready !== 1'b1)
      $display("FAIL um_accept got v=%b rdy=%b want 00 1",
               tgt_cmd_v, cmd_ready);
    else pass_cnt++;
    sb.push_back('{err: 1'b1, data: '0});
    @(negedge clk);
    cmd_v = 1'b0;
    #1;
    total_cnt++;
    if (resp_v !== 1'b1 || resp_err !== sb[0].err || resp !== sb[0].data)
      $display("FAIL um_resp got v=%b e=%b d=%h want 1 1 0",
               resp_v, resp_err, resp);
    else pass_cnt++;
    total_cnt++;
    if (err_count !== EW'(1))
      $display("FAIL um_count got %0d want 1", err_count);
    else pass_cnt++;
    resp_yumi = 1'b1;
    #1;
    total_cnt++;
    if (tgt_resp_yumi !== 2'b00)
      $display("FAIL um_yumi got %b want 00", tgt_resp_yumi);
    else pass_cnt++;
    void'(sb.pop_front());
    @(negedge clk);
    idle();
    #1;
    total_cnt++;
    if (outstanding !== '0 || err_count !== EW'(1))
      $display("FAIL um_drain got out=%0d err=%0d want 0 1",
               outstanding, err_count);
    else pass_cnt++;
  endtask

  task automatic test_full();
    logic [MW-1:0] r;
    do_reset();
    set_map(40'h8000_0000, MASK_A, 40'h0, MASK_A);
    tgt_cmd_ready = 2'b11;
    for (int i = 0; i < MO; i++) begin
      @(negedge clk);
      cmd = rnd();
      cmd_addr = 40'h8000_0000 + AW'(i * 64);
      cmd_v = 1'b1;
      #1;
      total_cnt++;
      if (cmd_ready !== 1'b1)
        $display("FAIL full_fill%0d got rdy=%b want 1", i, cmd_ready);
      else pass_cnt++;
      r = rnd();
      sb.push_back('{err: 1'b0, data: r});
      t0q.push_back(r);
    end
    @(negedge clk);
    cmd_addr = 40'h8000_0400;
    #1;
    total_cnt++;
    if (outstanding !== CW'(MO) || cmd_ready !== 1'b0 || tgt_cmd_v !== 2'b00)
      $display("FAIL full_stall got out=%0d rdy=%b v=%b want %0d 0 00",
               outstanding, cmd_ready, tgt_cmd_v, MO);
    else pass_cnt++;
    @(negedge clk);
    tgt_resp[0 +: MW] = t0q[0];
    tgt_resp_v = 2'b01;
    resp_yumi = 1'b1;
    #1;
    total_cnt++;
    if (cmd_ready !== 1'b0 || resp !== sb[0].data)
      $display("FAIL full_pop_push got rdy=%b d=%h want 0 %h",
               cmd_ready, resp, sb[0].data);
    else pass_cnt++;
    void'(sb.pop_front());
    void'(t0q.pop_front());
    @(negedge clk);
    resp_yumi = 1'b0;
    tgt_resp_v = 2'b00;
    #1;
    total_cnt++;
    if (outstanding !== CW'(MO - 1) || cmd_ready !== 1'b1)
      $display("FAIL full_retry got out=%0d rdy=%b want %0d 1",
               outstanding, cmd_ready, MO - 1);
    else pass_cnt++;
    r = rnd();
    sb.push_back('{err: 1'b0, data: r});
    t0q.push_back(r);
    @(negedge clk);
    cmd_v = 1'b0;
    #1;
    total_cnt++;
    if (outstanding !== CW'(MO))
      $display("FAIL full_refill got %0d want %0d", outstanding, MO);
    else pass_cnt++;
    for (int i = 0; i < MO; i++) begin
      @(negedge clk);
      tgt_resp[0 +: MW] = t0q[0];
      tgt_resp_v = 2'b01;
      resp_yumi = 1'b1;
      #1;
      total_cnt++;
      if (resp_v !== 1'b1 || resp_err !== 1'b0 || resp !== sb[0].data)
        $display("FAIL full_drain%0d got v=%b e=%b d=%h want 1 0 %h",
                 i, resp_v, resp_err, resp, sb[0].data);
      else pass_cnt++;
      void'(sb.pop_front());
      void'(t0q.pop_front());
    end
    @(negedge clk);
    idle();
    #1;
    total_cnt++;
    if (outstanding !== '0 || err_count !== '0)
      $display("FAIL full_empty got out=%0d err=%0d want 0 0",
               outstanding, err_count);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [MW-1:0] r;
    do_reset();
    set_map(40'h8000_0000, MASK_A, 40'h0, MASK_A);
    tgt_cmd_ready = 2'b10;
    @(negedge clk);
    cmd = rnd();
    cmd_addr = 40'h8000_0800;
    cmd_v = 1'b1;
    #1;
    total_cnt++;
    if (cmd_ready !== 1'b0 || tgt_cmd_v !== 2'b01)
      $display("FAIL bp_stall got rdy=%b v=%b want 0 01",
               cmd_ready, tgt_cmd_v);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (outstanding !== '0)
      $display("FAIL bp_noenq got %0d want 0", outstanding);
    else pass_cnt++;
    tgt_cmd_ready = 2'b11;
    #1;
    total_cnt++;
    if (cmd_ready !== 1'b1)
      $display("FAIL bp_release got %b want 1", cmd_ready);
    else pass_cnt++;
    r = rnd();
    sb.push_back('{err: 1'b0, data: r});
    @(negedge clk);
    cmd_v = 1'b0;
    #1;
    total_cnt++;
    if (outstanding !== CW'(1))
      $display("FAIL bp_single got %0d want 1", outstanding);
    else pass_cnt++;
    tgt_resp[0 +: MW] = r;
    tgt_resp_v = 2'b01;
    resp_yumi = 1'b1;
    #1;
    total_cnt++;
    if (resp_v !== 1'b1 || resp !== sb[0].data)
      $display("FAIL bp_resp got v=%b d=%h want 1 %h",
               resp_v, resp, sb[0].data);
    else pass_cnt++;
    void'(sb.pop_front());
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_map(40'h8000_0000, MASK_A, 40'h0, MASK_A);
    tgt_cmd_ready = 2'b11;
    @(negedge clk);
    cmd_addr = 40'h8000_0000;
    cmd_v = 1'b1;
    @(negedge clk);
    cmd_addr = 40'hFF_0000_0000;
    @(negedge clk);
    cmd_addr = 40'h0000_0100;
    @(negedge clk);
    cmd_v = 1'b0;
    #1;
    total_cnt++;
    if (outstanding !== CW'(3) || err_count !== EW'(1))
      $display("FAIL mid_pre got out=%0d err=%0d want 3 1",
               outstanding, err_count);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total_cnt++;
    if (outstanding !== '0 || resp_v !== 1'b0 || err_count !== '0)
      $display("FAIL mid_post got out=%0d rv=%b err=%0d want 0 0 0",
               outstanding, resp_v, err_count);
    else pass_cnt++;
    sb.delete();
  endtask

  initial begin
    reset = 1'b1;
    base = '0;
    mask = '0;
    tgt_cmd_ready = '0;
    idle();
    test_reset();
    test_single_hit();
    test_reorder();
    test_unmapped();
    test_full();
    test_backpressure();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
